// File: rtl/booth_csa_accum_if.sv
// Request/result bundle for booth_csa_accum: the start handshake, the operands,
// and the carry-save (sum, carry) result pair.
interface booth_csa_accum_if #(
  parameter int WIDTH = 32
);
  logic               start;
  logic [WIDTH-1:0]   a;
  logic [WIDTH-1:0]   b;
  logic               busy;
  logic               done;
  logic [2*WIDTH-1:0] sum_vec;
  logic [2*WIDTH-1:0] carry_vec;

  modport master (
    output start, a, b,
    input  busy, done, sum_vec, carry_vec
  );

  modport slave (
    input  start, a, b,
    output busy, done, sum_vec, carry_vec
  );
endinterface

// File: rtl/booth_csa_accum.sv
// Iterative radix-4 Booth multiplier front end: one digit per clock into a
// carry-save accumulator. Optional macro BOOTH_EARLY_EXIT_EN stops once the remaining digits are zero.
module booth_csa_accum #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  booth_csa_accum_if.slave   bus
);
  localparam int PW = 2 * WIDTH;
  localparam int ND = WIDTH / 2;
  localparam int CW = $clog2(ND) + 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   mcand_q, mcand_d;   // a sign-extended, pre-shifted by 2i
  logic [WIDTH:0]  mplr_q,  mplr_d;    // {b,0} arithmetic-shifted right by 2i
  logic [PW-1:0]   sum_q,   sum_d;
  logic [PW-1:0]   carry_q, carry_d;
  logic [CW-1:0]   idx_q,   idx_d;

  logic [PW-1:0]   m2, pp, sum_nx, maj, carry_nx;
  logic [2:0]      digit;
  logic            last_digit;

  assign digit = mplr_q[2:0];
  assign m2    = {mcand_q[PW-2:0], 1'b0};

  always_comb begin
    pp = '0;
    unique case (digit)
      3'b001, 3'b010: pp = mcand_q;
      3'b011:         pp = m2;
      3'b100:         pp = ~m2 + PW'(1);
      3'b101, 3'b110: pp = ~mcand_q + PW'(1);
      default:        pp = '0;
    endcase
  end

  // 3:2 compression; the carry word is stored already aligned
  assign sum_nx   = sum_q ^ carry_q ^ pp;
  assign maj      = (sum_q & carry_q) | (sum_q & pp) | (carry_q & pp);
  assign carry_nx = {maj[PW-2:0], 1'b0};

`ifdef BOOTH_EARLY_EXIT_EN
  // mplr_q[WIDTH:2] holds b[WIDTH-1:2i+1] plus sign copies; all-equal means no
  // nonzero digits remain after this one.
  assign last_digit = (&mplr_q[WIDTH:2]) | ~(|mplr_q[WIDTH:2]) ||
                      (idx_q == CW'(ND - 1));
`else
  assign last_digit = (idx_q == CW'(ND - 1));
`endif

  always_comb begin
    state_d = state_q;
    mcand_d = mcand_q;
    mplr_d  = mplr_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    idx_d   = idx_q;
    unique case (state_q)
      S_IDLE, S_DONE: begin
        state_d = S_IDLE;
        if (bus.start) begin
          mcand_d = {{WIDTH{bus.a[WIDTH-1]}}, bus.a};
          mplr_d  = {bus.b, 1'b0};
          sum_d   = '0;
          carry_d = '0;
          idx_d   = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        sum_d   = sum_nx;
        carry_d = carry_nx;
        mcand_d = {mcand_q[PW-3:0], 2'b00};
        mplr_d  = {{2{mplr_q[WIDTH]}}, mplr_q[WIDTH:2]};
        idx_d   = idx_q + CW'(1);
        if (last_digit) state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      mcand_q <= '0;
      mplr_q  <= '0;
      sum_q   <= '0;
      carry_q <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      mcand_q <= mcand_d;
      mplr_q  <= mplr_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      idx_q   <= idx_d;
    end
  end

  assign bus.busy      = (state_q == S_RUN);
  assign bus.done      = (state_q == S_DONE);
  assign bus.sum_vec   = sum_q;
  assign bus.carry_vec = carry_q;
endmodule

// File: tb/tb_booth_csa_accum.sv
// Scoreboard bench for booth_csa_accum: expected product and latency are queued
// at each accepted start and checked on every done pulse.
module tb_booth_csa_accum;
  localparam int W = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   nchk = 0;
  int   nerr = 0;

  typedef struct {
    logic [2*W-1:0] prod;
    int             lat;
    int             cyc0;
  } exp_t;
  exp_t sbq[$];
  exp_t mon_e;

  booth_csa_accum_if #(.WIDTH(W)) bus ();

  booth_csa_accum #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h want %h", tag, act, exp);
    end
  endtask

  function automatic int model_lat(input logic [W-1:0] b);
`ifdef BOOTH_EARLY_EXIT_EN
    logic same;
    for (int i = 0; i < W/2; i++) begin
      same = 1'b1;
      for (int k = 2*i + 1; k < W; k++) if (b[k] != b[W-1]) same = 1'b0;
      if (same) return i + 1;
    end
`endif
    return W/2;
  endfunction

  task automatic push(input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    logic signed [2*W-1:0] sa, sb;
    sa = {{W{a[W-1]}}, a};
    sb = {{W{b[W-1]}}, b};
    e.prod = sa * sb;
    e.lat  = model_lat(b);
    e.cyc0 = cyc;
    sbq.push_back(e);
  endtask

  // drive at negedge, take the accepting edge, then register the expectation
  task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b, input bit expect_result);
    @(negedge clk);
    bus.start = 1'b1;
    bus.a     = a;
    bus.b     = b;
    @(posedge clk);
    #1;
    if (expect_result) push(a, b);
    bus.start = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sbq.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (sbq.size() != 0) begin
      chk("timeout", 64'(sbq.size()), 64'd0);
      sbq.delete();
    end
    @(negedge clk);
  endtask

  always @(negedge clk) begin
    if (bus.done) begin
      chk("busy_done_excl", {63'b0, bus.busy}, 64'd0);
      if (sbq.size() == 0) chk("unexpected_done", {63'b0, bus.done}, 64'd0);
      else begin
        mon_e = sbq.pop_front();
        chk("product", bus.sum_vec + bus.carry_vec, mon_e.prod);
        chk("latency", 64'(cyc - mon_e.cyc0), 64'(mon_e.lat));
      end
    end
  end

  task automatic chk_zero(input string tag);
    chk({tag, "_busy"},  {63'b0, bus.busy}, 64'd0);
    chk({tag, "_done"},  {63'b0, bus.done}, 64'd0);
    chk({tag, "_sum"},   bus.sum_vec,       64'd0);
    chk({tag, "_carry"}, bus.carry_vec,     64'd0);
  endtask

  logic [W-1:0] ta [8] = '{32'd3, 32'hFFFFFFF9, 32'h80000000, 32'h80000000,
                           32'd1234, 32'd77, 32'h7FFFFFFF, 32'hFFFFFFFF};
  logic [W-1:0] tb [8] = '{32'd5, 32'd6, 32'h80000000, 32'h7FFFFFFF,
                           32'd1, 32'h00010000, 32'h7FFFFFFF, 32'd0};

  initial begin
    bus.start = 1'b1;
    bus.a     = $urandom;
    bus.b     = $urandom;
    repeat (3) begin
      @(negedge clk);
      chk_zero("reset");
    end
    rst       = 1'b0;
    bus.start = 1'b0;

    foreach (ta[i]) begin
      launch(ta[i], tb[i], 1'b1);
      drain();
    end

    // start while busy is ignored
    launch(32'd100, 32'h40000003, 1'b1);
    repeat (5) @(negedge clk);
    bus.start = 1'b1; bus.a = 32'd9; bus.b = 32'd9;
    @(negedge clk);
    bus.start = 1'b0;
    drain();

    // start held through DONE is accepted back-to-back
    launch(32'd7, 32'h20000001, 1'b1);
    @(negedge clk);
    bus.start = 1'b1; bus.a = 32'd2; bus.b = 32'd2;
    begin
      int n = 0;
      while (!bus.done && n < 200) begin
        @(negedge clk);
        n++;
      end
      chk("held_start_done_seen", {63'b0, bus.done}, 64'd1);
    end
    @(posedge clk);
    #1;
    push(32'd2, 32'd2);
    bus.start = 1'b0;
    drain();

    // reset mid-RUN discards the operation
    launch(32'd5, 32'h70000005, 1'b0);
    repeat (8) @(negedge clk);
    #2 rst = 1'b1;
    #1 chk_zero("midrst_async");
    @(posedge clk);
    @(negedge clk);
    chk_zero("midrst_held");
    rst = 1'b0;
    repeat (20) @(negedge clk);
    chk("midrst_idle_busy", {63'b0, bus.busy}, 64'd0);
    launch(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1);
    drain();

    for (int r = 0; r < 300; r++) begin
      launch($urandom, (r % 4 == 0) ? ($urandom >> (r % 31)) : $urandom, 1'b1);
      drain();
    end

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
